// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared constants and scoreboard entry type for hazard logic   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  // Stage indices after ID; larger index means an older instruction.
  localparam int ST_EX  = 1;
  localparam int ST_MEM = 2;
  localparam int ST_WB  = 3;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  v;
    logic [REG_AW_DEF-1:0] rd;
    logic                  ld;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_scoreboard_sb_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sb_match : youngest-match search of one source operand over the          |
// |            scoreboard entries. Rev 1.0                                   |
// +--------------------------------------------------------------------------+
module sb_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = 3,
  parameter int KW     = 2
) (
  input  logic                    i_used,
  input  logic [REG_AW-1:0]       i_src,
  input  logic [DEPTH-1:0]        i_v,
  input  logic [DEPTH*REG_AW-1:0] i_rd,
  input  logic [DEPTH-1:0]        i_ld,
  output logic                    o_hit,
  output logic [KW-1:0]           o_k,
  output logic                    o_ld
);

  // Scan oldest to youngest so the smallest matching stage overwrites the rest.
  always_comb begin
    o_hit = 1'b0;
    o_k   = '0;
    o_ld  = 1'b0;
    for (int k = DEPTH; k >= ST_EX; k--) begin
      if (i_used && i_v[k-1] && (i_src != '0) &&
          (i_rd[(k-1)*REG_AW +: REG_AW] == i_src)) begin
        o_hit = 1'b1;
        o_k   = KW'(k);
        o_ld  = i_ld[k-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_scoreboard : RAW hazard stall and EX forwarding-select       |
// |                          generator beside the decode stage. Rev 1.0      |
// +--------------------------------------------------------------------------+
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int ALU_RDY = 2,
  parameter int LD_RDY  = 3,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_id_valid,
  input  logic                      i_id_wr_en,
  input  logic [REG_AW-1:0]         i_id_rd,
  input  logic                      i_id_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] i_id_src,
  input  logic [NUM_SRC-1:0]        i_id_src_used,
  input  logic                      i_freeze,
  input  logic                      i_flush,
  output logic                      o_stall,
  output logic                      o_issue,
  output logic [NUM_SRC*SEL_W-1:0]  o_ex_fwd_sel,
  output logic [CNT_W-1:0]          o_stall_count
);

  // Scoreboard bit/field k-1 holds stage k (EX is the lowest slot).
  logic [DEPTH-1:0]         r_v;
  logic [DEPTH-1:0]         r_ld;
  logic [DEPTH*REG_AW-1:0]  r_rd;
  logic [NUM_SRC*SEL_W-1:0] r_sel;
  logic [CNT_W-1:0]         r_cnt;

  logic [NUM_SRC-1:0]       w_haz;
  logic [NUM_SRC*SEL_W-1:0] w_sel;
  logic                     w_live;
  logic                     w_stall;
  logic                     w_issue;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic             w_hit;
      logic             w_ld;
      logic [SEL_W-1:0] w_k;

      sb_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .KW     (SEL_W)
      ) u_match (
        .i_used (i_id_src_used[i]),
        .i_src  (i_id_src[i*REG_AW +: REG_AW]),
        .i_v    (r_v),
        .i_rd   (r_rd),
        .i_ld   (r_ld),
        .o_hit  (w_hit),
        .o_k    (w_k),
        .o_ld   (w_ld)
      );

      // Producer one stage further on next cycle must already hold its result.
      assign w_haz[i] = w_hit && ((int'(w_k) + 1) < (w_ld ? LD_RDY : ALU_RDY));
      // A producer reaching WB is covered by the write-first register file.
      assign w_sel[i*SEL_W +: SEL_W] = (w_hit && ((int'(w_k) + 1) <= (DEPTH - 1)))
                                     ? SEL_W'(int'(w_k) + 1) : SEL_W'(FWD_RF);
    end
  endgenerate

  assign w_live  = i_id_valid & ~i_flush & ~i_freeze;
  assign w_stall = w_live & (|w_haz);
  assign w_issue = w_live & ~w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_ld  <= '0;
      r_rd  <= '0;
      r_sel <= '0;
      r_cnt <= '0;
    end else if (!i_freeze) begin
      r_v   <= {r_v[DEPTH-2:0], w_issue & i_id_wr_en};
      r_ld  <= {r_ld[DEPTH-2:0], i_id_is_load};
      r_rd  <= {r_rd[(DEPTH-1)*REG_AW-1:0], i_id_rd};
      r_sel <= w_issue ? w_sel : '0;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stall       = w_stall;
  assign o_issue       = w_issue;
  assign o_ex_fwd_sel  = r_sel;
  assign o_stall_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_scoreboard : directed vector table plus randomized run    |
// |                             against a producer-list reference. Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int ALU_RDY = 2;
  localparam int LD_RDY  = 3;
  localparam int CNT_W   = 2;
  localparam int SEL_W   = $clog2(DEPTH + 1);
  localparam int NRAND   = 2000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_valid, id_wr_en, id_is_load, freeze, flush;
  logic [REG_AW-1:0]         id_rd;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      stall, issue;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
  logic [CNT_W-1:0]          stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .ALU_RDY (ALU_RDY),
    .LD_RDY  (LD_RDY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_id_valid    (id_valid),
    .i_id_wr_en    (id_wr_en),
    .i_id_rd       (id_rd),
    .i_id_is_load  (id_is_load),
    .i_id_src      (id_src),
    .i_id_src_used (id_src_used),
    .i_freeze      (freeze),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_issue       (issue),
    .o_ex_fwd_sel  (ex_fwd_sel),
    .o_stall_count (stall_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [REG_AW-1:0] rd,
                       input logic ld, input logic [REG_AW-1:0] s0,
                       input logic [REG_AW-1:0] s1, input logic [1:0] u,
                       input logic frz, input logic fl);
    id_valid    = v;
    id_wr_en    = wr;
    id_rd       = rd;
    id_is_load  = ld;
    id_src      = {s1, s0};
    id_src_used = u;
    freeze      = frz;
    flush       = fl;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             v, wr, ld, frz, fl;
    logic [REG_AW-1:0] rd, s0, s1;
    logic [1:0]       u;
    logic             e_stall, e_issue;
    logic [3:0]       e_sel;
    logic [1:0]       e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic wr, input int rd, input logic ld,
                              input int s0, input int s1, input logic [1:0] u,
                              input logic frz, input logic fl, input logic es,
                              input logic ei, input logic [3:0] esel, input logic [1:0] ecnt);
    vec_t t;
    t.v = v; t.wr = wr; t.rd = rd[REG_AW-1:0]; t.ld = ld;
    t.s0 = s0[REG_AW-1:0]; t.s1 = s1[REG_AW-1:0]; t.u = u;
    t.frz = frz; t.fl = fl;
    t.e_stall = es; t.e_issue = ei; t.e_sel = esel; t.e_cnt = ecnt;
    return t;
  endfunction

  // ---------------- reference model: list of in-flight producers ----------------
  typedef struct {
    logic [REG_AW-1:0] rd;
    logic              ld;
    int                stage;
  } prod_t;

  prod_t                    q[$];
  logic [NUM_SRC*SEL_W-1:0] m_sel;
  int                       m_cnt;

  task automatic model_reset();
    q.delete();
    m_sel = '0;
    m_cnt = 0;
  endtask

  task automatic model_eval(output logic st, output logic is,
                            output logic [NUM_SRC*SEL_W-1:0] ns);
    logic              haz;
    logic [REG_AW-1:0] src;
    int                best;
    int                rdy;
    logic              bld;
    haz = 1'b0;
    ns  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src  = id_src[i*REG_AW +: REG_AW];
      best = DEPTH + 1;
      bld  = 1'b0;
      foreach (q[j]) begin
        if (q[j].rd == src && q[j].stage < best) begin
          best = q[j].stage;
          bld  = q[j].ld;
        end
      end
      if (id_src_used[i] && src != '0 && best <= DEPTH) begin
        rdy = bld ? LD_RDY : ALU_RDY;
        if (best + 1 < rdy) haz = 1'b1;
        if (best + 1 <= DEPTH - 1) ns[i*SEL_W +: SEL_W] = SEL_W'(best + 1);
      end
    end
    st = id_valid & ~flush & ~freeze & haz;
    is = id_valid & ~flush & ~freeze & ~st;
  endtask

  task automatic model_update(input logic st, input logic is,
                              input logic [NUM_SRC*SEL_W-1:0] ns);
    prod_t nq[$];
    prod_t p;
    if (!freeze) begin
      foreach (q[j]) begin
        p = q[j];
        p.stage = p.stage + 1;
        if (p.stage <= DEPTH) nq.push_back(p);
      end
      if (is && id_wr_en && id_rd != '0) begin
        p.rd = id_rd; p.ld = id_is_load; p.stage = 1;
        nq.push_back(p);
      end
      q     = nq;
      m_sel = is ? ns : '0;
      if (st && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  initial begin
    logic                     ms, mi;
    logic [NUM_SRC*SEL_W-1:0] mn;

    //          v  wr rd ld s0  s1  u      frz fl  st is sel   cnt
    tbl.push_back(mk(1, 1, 3, 0, 1,  2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd0)); // add r3
    tbl.push_back(mk(1, 1, 4, 0, 3,  3,  2'b11, 0, 0, 0, 1, 4'h0, 2'd0)); // sub r4,r3,r3
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'hA, 2'd0)); // sel {2,2}
    tbl.push_back(mk(1, 1, 5, 1, 0,  0,  2'b01, 0, 0, 0, 1, 4'h0, 2'd0)); // lw r5
    tbl.push_back(mk(1, 1, 6, 0, 5,  1,  2'b11, 0, 0, 1, 0, 4'h0, 2'd0)); // load-use
    tbl.push_back(mk(1, 1, 6, 0, 5,  1,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h0, 2'd1)); // WB producer -> RF
    tbl.push_back(mk(1, 1, 0, 0, 1,  2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1)); // writer r0
    tbl.push_back(mk(1, 0, 0, 0, 0,  0,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1)); // reader r0
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h0, 2'd1));
    tbl.push_back(mk(1, 1, 7, 0, 1,  2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1)); // three r7 writers
    tbl.push_back(mk(1, 1, 7, 0, 1,  2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1));
    tbl.push_back(mk(1, 1, 7, 0, 1,  2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1));
    tbl.push_back(mk(1, 0, 0, 0, 7,  2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd1)); // reader r7
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h2, 2'd1)); // youngest -> 2
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h0, 2'd1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h0, 2'd1));
    tbl.push_back(mk(1, 1, 8, 1, 0,  0,  2'b00, 0, 0, 0, 1, 4'h0, 2'd1)); // lw r8
    for (int f = 0; f < 5; f++)
      tbl.push_back(mk(1, 1, 9, 0, 8, 8, 2'b11, 1, 0, 0, 0, 4'h0, 2'd1)); // frozen
    tbl.push_back(mk(1, 1, 9, 0, 8,  8,  2'b11, 0, 0, 1, 0, 4'h0, 2'd1)); // stall resumes
    tbl.push_back(mk(1, 1, 9, 0, 8,  8,  2'b11, 0, 0, 0, 1, 4'h0, 2'd2));
    tbl.push_back(mk(1, 1, 10, 0, 1, 2,  2'b11, 0, 0, 0, 1, 4'h0, 2'd2)); // add r10
    tbl.push_back(mk(1, 0, 0, 0, 10, 9,  2'b11, 0, 0, 0, 1, 4'h0, 2'd2)); // reader r10,r9
    tbl.push_back(mk(1, 0, 0, 0, 10, 9,  2'b11, 1, 0, 0, 0, 4'h2, 2'd2)); // sel held frozen
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 1, 0, 0, 0, 4'h2, 2'd2));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h2, 2'd2));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h0, 2'd2));
    tbl.push_back(mk(1, 1, 11, 1, 0, 0,  2'b00, 0, 0, 0, 1, 4'h0, 2'd2)); // lw r11
    tbl.push_back(mk(1, 1, 13, 0, 11, 1, 2'b11, 0, 1, 0, 0, 4'h0, 2'd2)); // flushed
    tbl.push_back(mk(1, 1, 14, 0, 13, 11, 2'b11, 0, 0, 0, 1, 4'h0, 2'd2)); // r13 absent
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 4'h0, 2'd2));
    tbl.push_back(mk(1, 1, 15, 1, 0, 0,  2'b00, 0, 0, 0, 1, 4'h0, 2'd2)); // lw r15
    tbl.push_back(mk(1, 1, 16, 0, 15, 0, 2'b01, 0, 0, 1, 0, 4'h0, 2'd2));
    tbl.push_back(mk(1, 1, 16, 0, 15, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'd3));
    tbl.push_back(mk(1, 1, 15, 1, 0, 0,  2'b00, 0, 0, 0, 1, 4'h0, 2'd3));
    tbl.push_back(mk(1, 1, 16, 0, 15, 0, 2'b01, 0, 0, 1, 0, 4'h0, 2'd3));
    tbl.push_back(mk(1, 1, 16, 0, 15, 0, 2'b01, 0, 0, 0, 1, 4'h0, 2'd3)); // saturated

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_cnt", 32'(stall_count), 32'd0);
    chk("reset_sel", 32'(ex_fwd_sel), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_issue", 32'(issue), 32'd0);
    rst = 1'b0;

    foreach (tbl[n]) begin
      @(negedge clk);
      drive(tbl[n].v, tbl[n].wr, tbl[n].rd, tbl[n].ld, tbl[n].s0, tbl[n].s1,
            tbl[n].u, tbl[n].frz, tbl[n].fl);
      #1;
      chk($sformatf("v%0d_stall", n), 32'(stall), 32'(tbl[n].e_stall));
      chk($sformatf("v%0d_issue", n), 32'(issue), 32'(tbl[n].e_issue));
      chk($sformatf("v%0d_sel", n), 32'(ex_fwd_sel), 32'(tbl[n].e_sel));
      chk($sformatf("v%0d_cnt", n), 32'(stall_count), 32'(tbl[n].e_cnt));
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive(1, 1, 20, 1, 0, 0, 2'b00, 0, 0);
    #1 chk("rst_lw_issue", 32'(issue), 32'd1);
    @(negedge clk);
    drive(1, 0, 0, 0, 20, 0, 2'b01, 0, 0);
    #1 chk("rst_pre_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cnt", 32'(stall_count), 32'd0);
    chk("rst_async_sel", 32'(ex_fwd_sel), 32'd0);
    chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_issue", 32'(issue), 32'd1);
    @(posedge clk);
    #1 chk("rst_hold_cnt", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized run against the producer-list model.
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clk);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
            REG_AW'($urandom_range(0, 7)), ($urandom_range(0, 9) < 3),
            REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0));
      #1;
      model_eval(ms, mi, mn);
      chk($sformatf("r%0d_stall", c), 32'(stall), 32'(ms));
      chk($sformatf("r%0d_issue", c), 32'(issue), 32'(mi));
      chk($sformatf("r%0d_sel", c), 32'(ex_fwd_sel), 32'(m_sel));
      chk($sformatf("r%0d_cnt", c), 32'(stall_count), 32'(m_cnt));
      model_update(ms, mi, mn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-select block for the in-order MIPS-style pipeline; sits beside the decode stage.
- Tracks in-flight register writes in a shift-register scoreboard, one entry per stage after ID (EX, MEM, WB, ...).
- Detects RAW hazards for NUM_SRC source operands, stalls on per-class result latency, and emits registered forwarding selects aligned with EX.
- Adds what the fixed two-operand hazard/forwarding pair lacks: arbitrary pipeline depth, per-class ready stage, global freeze, decode flush and a stall performance counter.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands checked per instruction.
- DEPTH, 3, tracked stages after ID (1=EX ... DEPTH=WB); must be >= 2.
- ALU_RDY, 2, first stage index whose pipeline register holds an ALU result.
- LD_RDY, 3, first stage index holding load data; ALU_RDY <= LD_RDY <= DEPTH.
- CNT_W, 16, stall counter width.
- Derived: SEL_W = clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_wr_en  in  1  ID instruction writes a register.
- id_rd  in  REG_AW  destination register.
- id_is_load  in  1  destination is produced by a load (uses LD_RDY).
- id_src  in  NUM_SRC*REG_AW  source registers, src i at bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-source "operand actually read".
- freeze  in  1  global pipeline hold (memory wait).
- flush  in  1  squash the ID instruction this cycle.
- stall  out  1  combinational; hold PC and IF/ID, insert bubble.
- issue  out  1  combinational; ID instruction advances to EX this cycle.
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered; 0 = register file, s = forward from stage-s pipeline register.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard entry k (1..DEPTH) holds {v, rd, ld}. An entry is live only when v=1 and rd!=0; register 0 is never tracked and never forwarded.
- Match for src i: id_src_used[i], and some live entry has rd == src_i. If several entries match, the smallest k (youngest) wins.
- Ready stage of the matched producer: R = LD_RDY if ld, else ALU_RDY.
- Hazard for src i: a match exists and k+1 < R.
  - Default case: a load in EX against a dependent instruction in ID gives 1 stall cycle.
  - Larger LD_RDY gives (LD_RDY-1-k) consecutive stall cycles.
- stall = id_valid & ~flush & ~freeze & (OR of hazards).
- issue = id_valid & ~flush & ~freeze & ~stall.
- Each clock edge with freeze=0:
  - entries shift, k -> k+1; entry DEPTH is dropped;
  - entry 1 gets {issue & id_wr_en, id_rd, id_is_load};
  - stall or flush inserts a bubble (v=0).
- ex_fwd_sel, loaded on each freeze=0 edge with:
  - the value computed for the issuing instruction when issue=1;
  - otherwise 0 for all sources.
- Per-source select: k+1 when a match exists and k+1 <= DEPTH-1; otherwise 0.
  - Producer already in WB (k = DEPTH) reads via the write-first register file, so it selects 0.
- freeze=1: all state (scoreboard, ex_fwd_sel, stall_count) holds; stall=issue=0. freeze dominates flush and hazards.
- flush=1 with a hazard pending: no stall (the instruction dies), and a bubble enters EX.
- stall_count increments on each edge with stall=1 and saturates at all-ones (no wrap).
- Reset (asynchronous, any time, including mid-stall): all v=0, rd=0, ld=0, ex_fwd_sel=0, stall_count=0. stall/issue then depend only on inputs, with an empty scoreboard.
- Latency: hazard decision is same-cycle; forwarding select is valid in EX one cycle after issue.

Decomposition:
- Shared package pipe_pkg: REG_AW default, stage-index constants (ST_EX=1, ST_MEM=2, ST_WB=3), FWD_RF=0, scoreboard entry struct {v, rd, ld}.
- One sub-module, sb_match: combinational per-source youngest-match priority search, returning {hit, k, ld}, instantiated NUM_SRC times.

Test Plan:
- Reset, then issue add r3 (ALU) and next cycle sub r4,r3,r3 -> stall=0, ex_fwd_sel = {2,2} in the following cycle.
- lw r5, then add r6,r5,r1 -> exactly one stall cycle (stall_count=1); after the bubble, src0 sel=3 with DEPTH=4, sel=0 with DEPTH=3.
- Writer r0 followed by a reader of r0 -> no stall, sel=0; three writers r7 in flight -> reader selects the youngest (sel=2).
- freeze held 5 cycles during a load-use stall -> scoreboard, ex_fwd_sel and stall_count unchanged; stall=0 while frozen; stall resumes for 1 cycle after release.
- flush asserted with a load-use hazard present -> stall=0, issue=0, bubble in EX, stall_count unchanged.
- CNT_W=2 with 5 stall cycles -> stall_count saturates at 3; asserting rst mid-stall clears it to 0 asynchronously.
